// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Two-master arbiter in front of the unified single-port instruction/data
// memory. Master 0 is the core's multi-cycle memory port and master 1 is the
// program loader / debug host. The arbiter owns the memory address, write
// data and write enable. It returns read data to the granted master and
// gives each master an explicit, registered grant.
//
// Handshake: a master raises mX_req and holds it. Once mX_gnt is high, every
// cycle with mX_req && mX_gnt is one memory access. Reads return
// combinationally in that cycle, and writes (mX_we) commit at the closing
// rising edge. Dropping mX_req releases the port at the next edge. A waiting
// request is never lost while it is held.
//
// Optional feature (macro MEM_ARB_BURST_LIMIT_EN): an 8-bit burst counter
// forces a handover once the owner has held the port for BURST_MAX
// consecutive cycles while the other master was requesting. Without the
// macro, a grant is held until the owner drops its request.
//
// Parameters:
//   ADDR_W     address width
//   DATA_W     data width
//   BURST_MAX  contended cycles before forced handover (1..255, macro only)
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   m0_req/m0_we        core request / write strobe
//   m0_addr/m0_wdata    core address / write data
//   m0_gnt              core owns the port (flop)
//   m0_rdata            read data to core (0 when not granted)
//   m1_*                same set for loader/debug master
//   mem_addr/mem_wdata  to memory A / WD (0 when idle)
//   mem_we              to memory WE
//   mem_rdata           from memory RD (combinational read)
//   owner               last or current owner (0 = m0, 1 = m1)
//   busy                a master is granted
//   dbg_state           raw FSM state for observation (0 IDLE, 1 OWN0, 2 OWN1)

module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   owner_q;
    logic   preempt;

    // ------------------------------------------------------------------
    // Burst limiter
    // ------------------------------------------------------------------
`ifdef MEM_ARB_BURST_LIMIT_EN
    // Preempt in the cycle that would bring the count to BURST_MAX. This
    // way the owner loses the port after exactly BURST_MAX contended cycles.
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    logic [7:0] burst_cnt;
    logic       other_req;

    always_comb begin
        other_req = 1'b0;
        case (state)
            OWN0:    other_req = m1_req;
            OWN1:    other_req = m0_req;
            default: other_req = 1'b0;
        endcase
    end

    assign preempt = other_req && (burst_cnt == BURST_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= 8'd0;
        end else if ((next_state != state) || !other_req) begin
            burst_cnt <= 8'd0;
        end else begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    // Round-robin: the master that did not own last wins.
                    next_state = owner_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    next_state = OWN0;
                end else if (m1_req) begin
                    next_state = OWN1;
                end else begin
                    next_state = IDLE;
                end
            end
            OWN0: begin
                // Release goes straight to the other master when it waits,
                // with no idle bubble in between.
                if (m0_req && !preempt) begin
                    next_state = OWN0;
                end else if (m1_req) begin
                    next_state = OWN1;
                end else begin
                    next_state = IDLE;
                end
            end
            OWN1: begin
                if (m1_req && !preempt) begin
                    next_state = OWN1;
                end else if (m0_req) begin
                    next_state = OWN0;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and owner flops
    // ------------------------------------------------------------------
    // owner resets to 1 so that m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            owner_q <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state == OWN0) begin
                owner_q <= 1'b0;
            end else if (next_state == OWN1) begin
                owner_q <= 1'b1;
            end
        end
    end

    // Grants come straight off the state flops, so they are glitch-free.
    // They also drop as soon as reset is asserted.
    assign m0_gnt    = (state == OWN0);
    assign m1_gnt    = (state == OWN1);
    assign busy      = (state != IDLE);
    assign owner     = owner_q;
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Memory mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        case (state)
            OWN0: begin
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_we & m0_req & m0_gnt;
                m0_rdata  = mem_rdata;
            end
            OWN1: begin
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_we & m1_req & m1_gnt;
                m1_rdata  = mem_rdata;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              m0_req, m0_we, m0_gnt;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_gnt;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;
    logic              owner, busy;
    logic [1:0]        dbg_state;

    int passed;
    int total;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_MAX(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rdata (m1_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .owner    (owner),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word-indexed by the low address byte, combinational read.
    // Initial contents are 0xA50000nn, so every read value is predictable.
    logic [DATA_W-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    end
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) $display("FAIL reset_gnt: m0_gnt=%b m1_gnt=%b expected 0 0", m0_gnt, m1_gnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b expected 0", busy); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: mem_we=%b expected 0", mem_we); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL reset_owner: owner=%b expected 1", owner); else passed++;
        total++; if (dbg_state !== 2'd0) $display("FAIL reset_state: state=%0d expected 0", dbg_state); else passed++;
        reset = 1;
        tick();
    endtask

    task automatic test_single_grant();
        m0_req = 1; m0_addr = 32'h10;
        tick();
        total++; if (m0_gnt !== 1'b1) $display("FAIL single_gnt: m0_gnt=%b expected 1", m0_gnt); else passed++;
        total++; if (owner !== 1'b0) $display("FAIL single_owner: owner=%b expected 0", owner); else passed++;
        total++; if (mem_addr !== 32'h10) $display("FAIL single_addr: mem_addr=%h expected 00000010", mem_addr); else passed++;
        total++; if (m0_rdata !== 32'hA500_0010) $display("FAIL single_rdata: m0_rdata=%h expected a5000010", m0_rdata); else passed++;
        total++; if (m1_rdata !== 32'h0) $display("FAIL single_m1_rdata: m1_rdata=%h expected 0", m1_rdata); else passed++;
        m0_req = 0;
        tick();
        total++; if (m0_gnt !== 1'b0 || busy !== 1'b0) $display("FAIL single_release: m0_gnt=%b busy=%b expected 0 0", m0_gnt, busy); else passed++;
        total++; if (owner !== 1'b0) $display("FAIL single_owner_hold: owner=%b expected 0", owner); else passed++;
    endtask

    task automatic test_round_robin();
        reset = 0; #2; reset = 1;
        tick();
        m0_req = 1; m1_req = 1;
        tick();
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL rr_first: m0_gnt=%b m1_gnt=%b expected 1 0", m0_gnt, m1_gnt); else passed++;
        m0_req = 0;
        tick();
        total++; if (m1_gnt !== 1'b1 || busy !== 1'b1) $display("FAIL rr_handover: m1_gnt=%b busy=%b expected 1 1", m1_gnt, busy); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL rr_owner: owner=%b expected 1", owner); else passed++;
        m1_req = 0;
        tick();
        m0_req = 1; m1_req = 1;
        tick();
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL rr_second: m0_gnt=%b m1_gnt=%b expected 1 0", m0_gnt, m1_gnt); else passed++;
        m0_req = 0; m1_req = 0;
        tick();
    endtask

    task automatic test_write_protect();
        m1_req = 1;
        tick();
        m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEAD_BEEF;
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h1234_5678;
        #1;
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wp_drive: mem_we=%b mem_wdata=%h expected 1 deadbeef", mem_we, mem_wdata); else passed++;
        total++; if (m0_gnt !== 1'b0 || m0_rdata !== 32'h0) $display("FAIL wp_m0_blocked: m0_gnt=%b m0_rdata=%h expected 0 0", m0_gnt, m0_rdata); else passed++;
        tick();
        m1_we = 0;
        #1;
        total++; if (mem[32] !== 32'hDEAD_BEEF) $display("FAIL wp_commit: mem[0x20]=%h expected deadbeef", mem[32]); else passed++;
        m0_we = 0; m1_req = 0;
        tick();
        total++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) $display("FAIL wp_m0_gnt: m0_gnt=%b mem_we=%b expected 1 0", m0_gnt, mem_we); else passed++;
        total++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL wp_readback: m0_rdata=%h expected deadbeef", m0_rdata); else passed++;
        m0_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'h55;
        tick();
        total++; if (mem_we !== 1'b1) $display("FAIL rmw_pre: mem_we=%b expected 1", mem_we); else passed++;
        #2;
        reset = 0;
        #1;
        total++; if (mem_we !== 1'b0 || m1_gnt !== 1'b0 || busy !== 1'b0) $display("FAIL rmw_async: mem_we=%b m1_gnt=%b busy=%b expected 0 0 0", mem_we, m1_gnt, busy); else passed++;
        tick();
        total++; if (mem[48] !== 32'hA500_0030) $display("FAIL rmw_no_write: mem[0x30]=%h expected a5000030", mem[48]); else passed++;
        m1_req = 0; m1_we = 0;
        reset = 1;
        tick();
        total++; if (dbg_state !== 2'd0 || owner !== 1'b1) $display("FAIL rmw_after: state=%0d owner=%b expected 0 1", dbg_state, owner); else passed++;
    endtask

    task automatic test_burst();
        int held;
        m0_req = 1; m0_addr = 32'h4;
        tick();
        m1_req = 1;
`ifdef MEM_ARB_BURST_LIMIT_EN
        repeat (3) tick();
        total++; if (m0_gnt !== 1'b1) $display("FAIL burst_hold3: m0_gnt=%b expected 1", m0_gnt); else passed++;
        tick();
        total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) $display("FAIL burst_preempt: m0_gnt=%b m1_gnt=%b expected 0 1", m0_gnt, m1_gnt); else passed++;
        repeat (3) tick();
        total++; if (m1_gnt !== 1'b1) $display("FAIL burst_m1_hold3: m1_gnt=%b expected 1", m1_gnt); else passed++;
        tick();
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL burst_regrant: m0_gnt=%b m1_gnt=%b expected 1 0", m0_gnt, m1_gnt); else passed++;
`else
        held = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (m0_gnt === 1'b1 && m1_gnt === 1'b0) held++;
        end
        total++; if (held !== 120) $display("FAIL burst_starve: m0 held %0d cycles expected 120", held); else passed++;
`endif
        m0_req = 0; m1_req = 0;
        tick();
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_we !== 1'b0 || mem_addr !== '0 || busy !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL idle_outputs: %0d bad cycles expected 0", bad); else passed++;
        total++; if (owner !== 1'b0) $display("FAIL idle_owner: owner=%b expected 0", owner); else passed++;
        total++; if (mem_wdata !== '0) $display("FAIL idle_wdata: mem_wdata=%h expected 0", mem_wdata); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_write_protect();
        test_reset_mid_write();
        test_burst();
        test_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
